// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci index finder.
// fib_min_idx_w() gives the index width needed to reach the first term above 2^WIDTH-1.
package fib_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } fib_state_e;

  localparam int              FIB_MAX_IDX    = 48;
  localparam longint unsigned FIB_MAX_TERM32 = 64'd2971215073;

  function automatic int fib_min_idx_w(input int width);
    longint unsigned lim;
    longint unsigned fa;
    longint unsigned fb;
    longint unsigned t;
    int              k;
    int              w;
    lim = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    fa  = 64'd0;
    fb  = 64'd1;
    k   = 0;
    while (fa <= lim && k < 93) begin
      t  = fa + fb;
      fa = fb;
      fb = t;
      k++;
    end
    w = 1;
    while ((1 << w) <= k) w++;
    return w;
  endfunction

endpackage

// File: rtl/fib_term_step.sv
// Walks the Fibonacci sequence one term per advance: a=F(k), b=F(k+1).
// load restarts the walk at F(0)/F(1); a has one guard bit so F(48) never wraps.
module fib_term_step
  import fib_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_advance,
  output logic [WIDTH:0]   o_a,
  output logic [IDX_W-1:0] o_k
);

  logic [WIDTH:0]   r_a;
  logic [WIDTH:0]   r_b;
  logic [IDX_W-1:0] r_k;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_k <= '0;
    end else if (i_load) begin
      r_a <= '0;
      r_b <= {{WIDTH{1'b0}}, 1'b1};
      r_k <= '0;
    end else if (i_advance) begin
      r_a <= r_b;
      r_b <= r_a + r_b;
      r_k <= r_k + 1'b1;
    end
  end

  assign o_a = r_a;
  assign o_k = r_k;

endmodule

// File: rtl/fib_index_finder.sv
// Returns the smallest k with F(k) >= value, whether value is exactly F(k),
// and whether F(k) exceeds WIDTH bits. One query in flight; start/busy/done handshake.
module fib_index_finder
  import fib_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             is_fib,
  output logic [IDX_W-1:0] index,
  output logic             ovf
);

  fib_state_e       r_state;
  fib_state_e       w_state_nxt;
  logic [WIDTH-1:0] r_target;
  logic             w_load;
  logic             w_advance;
  logic             w_finish;
  logic             w_hit;
  logic [WIDTH:0]   w_a;
  logic [IDX_W-1:0] w_k;
  logic             r_done;
  logic             r_is_fib;
  logic             r_ovf;
  logic [IDX_W-1:0] r_index;

  fib_term_step #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_step (
    .clk       (clk),
    .reset     (reset),
    .i_load    (w_load),
    .i_advance (w_advance),
    .o_a       (w_a),
    .o_k       (w_k)
  );

  // Guard bit of a stays in the compare so F(48) correctly beats any WIDTH-bit target.
  assign w_hit = (w_a >= {1'b0, r_target});

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_state_nxt = SEARCH;
        end
      end
      SEARCH: begin
        if (w_hit) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_advance = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Target is pure data: only meaningful once a start has been accepted.
  always_ff @(posedge clk) begin
    if (w_load) r_target <= value;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done   <= 1'b0;
      r_is_fib <= 1'b0;
      r_ovf    <= 1'b0;
      r_index  <= '0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_index  <= w_k;
        r_is_fib <= (w_a == {1'b0, r_target});
        r_ovf    <= w_a[WIDTH];
      end
    end
  end

  assign busy   = (r_state == SEARCH);
  assign done   = r_done;
  assign is_fib = r_is_fib;
  assign index  = r_index;
  assign ovf    = r_ovf;

endmodule
